// File: rtl/refill_arbiter.sv
// Round-robin arbiter sharing one line-wide memory refill port between the
// instruction cache and the data cache, one transaction at a time, with a watchdog.
module refill_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_res_valid,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req_valid,
    input  logic              dc_req_wen,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [LINE_W-1:0] dc_req_wdata,
    output logic              dc_res_valid,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_res_valid,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err_timeout
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);
    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic              last_dc;
    logic              grant_dc;
    logic [CNT_W-1:0]  wd_cnt;
    logic [LINE_W-1:0] rdata_q;
    logic              pick_dc_c;

    // On a tie the requester that did not win last time gets the port.
    assign pick_dc_c = dc_req_valid & (~ic_req_valid | ~last_dc);

    assign ic_rdata = rdata_q;
    assign dc_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_dc       <= 1'b1;
            grant_dc      <= 1'b0;
            wd_cnt        <= '0;
            rdata_q       <= '0;
            ic_res_valid  <= 1'b0;
            dc_res_valid  <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            ic_res_valid <= 1'b0;
            dc_res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_req_valid || dc_req_valid) begin
                        grant_dc      <= pick_dc_c;
                        mem_req_addr  <= (pick_dc_c ? dc_req_addr : ic_req_addr) & LINE_MASK;
                        mem_req_wen   <= pick_dc_c & dc_req_wen;
                        mem_req_wdata <= pick_dc_c ? dc_req_wdata : '0;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        wd_cnt        <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the final watchdog cycle still wins over the timeout.
                    if (mem_res_valid || wd_cnt == WD_LAST) begin
                        if (!mem_res_valid) begin
                            err_timeout <= 1'b1;
                        end
                        rdata_q      <= (mem_res_valid && !mem_req_wen) ? mem_rdata : '0;
                        ic_res_valid <= ~grant_dc & ic_req_valid;
                        dc_res_valid <= grant_dc & dc_req_valid;
                        state        <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    last_dc <= grant_dc;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_refill_arbiter.sv
// Directed plus randomized transactions against refill_arbiter, checked against
// expectations derived from the arbitration and watchdog rules.
module tb_refill_arbiter;
    localparam int AW = 64;
    localparam int LW = 128;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req_valid;
    logic [AW-1:0] ic_req_addr;
    logic          ic_res_valid;
    logic [LW-1:0] ic_rdata;
    logic          dc_req_valid;
    logic          dc_req_wen;
    logic [AW-1:0] dc_req_addr;
    logic [LW-1:0] dc_req_wdata;
    logic          dc_res_valid;
    logic [LW-1:0] dc_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_res_valid;
    logic [LW-1:0] mem_rdata;
    logic          busy;
    logic          err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    bit last_was_dc;
    bit err_m;

    refill_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
        .ic_res_valid(ic_res_valid), .ic_rdata(ic_rdata),
        .dc_req_valid(dc_req_valid), .dc_req_wen(dc_req_wen),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
        .dc_res_valid(dc_res_valid), .dc_rdata(dc_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_res_valid(mem_res_valid),
        .mem_rdata(mem_rdata), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction starting in IDLE: stall = ISSUE cycles with ready low,
    // dly = WAIT cycle in which memory answers (beyond TO means never).
    task automatic do_txn(input int stall, input int dly, input bit drop, input logic [LW-1:0] rd);
        bit            win_dc;
        bit            exp_wen;
        bit            timed_out;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wd;
        logic [LW-1:0] exp_data;
        if (ic_req_valid && dc_req_valid) win_dc = !last_was_dc;
        else                              win_dc = dc_req_valid;
        exp_addr  = win_dc ? dc_req_addr : ic_req_addr;
        exp_addr[3:0] = 4'h0;
        exp_wen   = win_dc && dc_req_wen;
        exp_wd    = dc_req_wdata;
        timed_out = dly > TO;

        chk("idle_busy", busy, 0);
        step();
        chk("issue_valid", mem_req_valid, 1);
        chk("issue_addr", mem_req_addr, exp_addr);
        chk("issue_wen", mem_req_wen, exp_wen);
        if (exp_wen) chk("issue_wdata", mem_req_wdata, exp_wd);
        chk("issue_busy", busy, 1);
        for (int s = 0; s < stall; s++) begin
            mem_req_ready = 1'b0;
            mem_res_valid = 1'($urandom_range(0, 1));
            mem_rdata     = rand_line();
            step();
            mem_res_valid = 1'b0;
            chk("stall_valid", mem_req_valid, 1);
            chk("stall_addr", mem_req_addr, exp_addr);
            if (exp_wen) chk("stall_wdata", mem_req_wdata, exp_wd);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("wait_valid", mem_req_valid, 0);
        for (int w = 1; w <= TO; w++) begin
            chk("wait_ic_pulse", ic_res_valid, 0);
            chk("wait_dc_pulse", dc_res_valid, 0);
            chk("wait_busy", busy, 1);
            if (drop && w == 1) begin
                if (win_dc) dc_req_valid = 1'b0;
                else        ic_req_valid = 1'b0;
            end
            if (w == dly) begin
                mem_res_valid = 1'b1;
                mem_rdata     = rd;
            end
            step();
            mem_res_valid = 1'b0;
            if (w == dly) break;
        end
        if (timed_out) err_m = 1'b1;
        exp_data = (timed_out || exp_wen) ? '0 : rd;
        chk("done_ic_pulse", ic_res_valid, !win_dc && !drop);
        chk("done_dc_pulse", dc_res_valid, win_dc && !drop);
        if (!drop) chk("done_data", win_dc ? dc_rdata : ic_rdata, exp_data);
        chk("done_err", err_timeout, err_m);
        chk("done_req_valid", mem_req_valid, 0);
        if (!drop) begin
            if (win_dc) dc_req_valid = 1'b0;
            else        ic_req_valid = 1'b0;
        end
        last_was_dc = win_dc;
        step();
        chk("post_ic_pulse", ic_res_valid, 0);
        chk("post_dc_pulse", dc_res_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ic_req_valid = 1'b0; ic_req_addr = '0;
        dc_req_valid = 1'b0; dc_req_wen = 1'b0; dc_req_addr = '0; dc_req_wdata = '0;
        mem_req_ready = 1'b0; mem_res_valid = 1'b0; mem_rdata = '0;
        last_was_dc = 1'b1;
        err_m = 1'b0;
        step();
        step();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_wen", mem_req_wen, 0);
        chk("rst_wdata", mem_req_wdata, 0);
        chk("rst_ic_pulse", ic_res_valid, 0);
        chk("rst_dc_pulse", dc_res_valid, 0);
        chk("rst_rdata", ic_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        step();

        // Repeated ties right after reset: ic, dc, ic, dc.
        for (int k = 0; k < 4; k++) begin
            if (!ic_req_valid) begin ic_req_valid = 1'b1; ic_req_addr = 64'h4000_0000 + AW'(k * 64 + 5); end
            if (!dc_req_valid) begin
                dc_req_valid = 1'b1; dc_req_wen = 1'b0;
                dc_req_addr = 64'h9000_0000 + AW'(k * 64 + 9); dc_req_wdata = rand_line();
            end
            do_txn(0, 1, 1'b0, rand_line());
        end
        do_txn(0, 1, 1'b0, rand_line());

        // Single icache refill at minimum latency.
        ic_req_valid = 1'b1; ic_req_addr = 64'h8000_1238;
        do_txn(0, 1, 1'b0, 128'hAAAAAAAAAAAAAAAA5555555555555555);

        // dcache write-back with ready held low for 5 cycles.
        dc_req_valid = 1'b1; dc_req_wen = 1'b1; dc_req_addr = 64'h8000_0040;
        dc_req_wdata = 128'h123456789ABCDEF0_0FEDCBA987654321;
        do_txn(5, 2, 1'b0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

        // icache flush during WAIT, then a normal request.
        ic_req_valid = 1'b1; ic_req_addr = 64'h0000_2004;
        do_txn(0, 3, 1'b1, rand_line());
        ic_req_valid = 1'b1; ic_req_addr = 64'h0000_3008;
        do_txn(1, 1, 1'b0, rand_line());

        // Memory never answers: watchdog fires, flag stays set.
        dc_req_valid = 1'b1; dc_req_wen = 1'b0; dc_req_addr = 64'h7000_00F0;
        do_txn(0, 100, 1'b0, rand_line());
        ic_req_valid = 1'b1; ic_req_addr = 64'h0000_5010;
        do_txn(0, 2, 1'b0, rand_line());

        // Reset in the middle of WAIT, then a late memory response.
        ic_req_valid = 1'b1; ic_req_addr = 64'h0000_6000;
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", mem_req_valid, 0);
        chk("midrst_addr", mem_req_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err_timeout, 0);
        chk("midrst_ic_pulse", ic_res_valid, 0);
        ic_req_valid = 1'b0;
        step();
        rst_n = 1'b1;
        err_m = 1'b0;
        last_was_dc = 1'b1;
        mem_res_valid = 1'b1;
        mem_rdata = rand_line();
        step();
        mem_res_valid = 1'b0;
        chk("late_ic_pulse", ic_res_valid, 0);
        chk("late_busy", busy, 0);
        step();
        chk("late_ic_pulse2", ic_res_valid, 0);
        chk("late_dc_pulse2", dc_res_valid, 0);

        // Randomized traffic with held requests, stalls, flushes and timeouts.
        for (int i = 0; i < 60; i++) begin
            if (!ic_req_valid && $urandom_range(0, 1) == 1) begin
                ic_req_valid = 1'b1; ic_req_addr = {$urandom, $urandom};
            end
            if (!dc_req_valid && ($urandom_range(0, 1) == 1 || !ic_req_valid)) begin
                dc_req_valid = 1'b1; dc_req_wen = 1'($urandom_range(0, 1));
                dc_req_addr = {$urandom, $urandom}; dc_req_wdata = rand_line();
            end
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(1, 10)),
                   $urandom_range(0, 5) == 0, rand_line());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
